// File: rtl/ttt_pkg.sv
// Shared types for the NxN, K-in-a-row board: cell/player codes, win codes,
// FSM states and scan directions.
package ttt_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        X     = 2'b01,
        O     = 2'b10
    } cell_t;

    typedef enum logic [1:0] {
        NONE = 2'b00,
        XWIN = 2'b01,
        OWIN = 2'b10,
        DRAW = 2'b11
    } win_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        CHECK = 2'b01,
        DONE  = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        DIR_ROW  = 2'd0,
        DIR_COL  = 2'd1,
        DIR_DIAG = 2'd2,
        DIR_ANTI = 2'd3
    } dir_t;

    function automatic cell_t other_player(cell_t p);
        return (p == X) ? O : X;
    endfunction

endpackage

// File: rtl/ttt_line_count.sv
// Combinational run counter: length of the same-player run through (row,col)
// along one direction, each side capped at K-1 cells and clipped at the edges.
module ttt_line_count
    import ttt_pkg::*;
#(
    parameter int N = 3,
    parameter int K = 3
) (
    input  logic [1:0]               board [N][N],
    input  logic [$clog2(N)-1:0]     row,
    input  logic [$clog2(N)-1:0]     col,
    input  dir_t                     dir,
    input  cell_t                    player,
    output logic [$clog2(2*K)-1:0]   count
);

    localparam int CW = $clog2(N);
    localparam int QW = $clog2(2*K);

    int   dr_s;
    int   dc_s;
    int   r_s;
    int   c_s;
    int   sgn_s;
    int   total_s;
    logic run_s;

    // walk outward on both sides until the run breaks or the board ends
    always_comb begin
        dr_s    = 0;
        dc_s    = 1;
        r_s     = 0;
        c_s     = 0;
        sgn_s   = 1;
        total_s = 1;
        run_s   = 1'b1;
        case (dir)
            DIR_ROW:  begin dr_s = 0; dc_s = 1;  end
            DIR_COL:  begin dr_s = 1; dc_s = 0;  end
            DIR_DIAG: begin dr_s = 1; dc_s = 1;  end
            DIR_ANTI: begin dr_s = 1; dc_s = -1; end
            default:  begin dr_s = 0; dc_s = 1;  end
        endcase
        for (int s = 0; s < 2; s++) begin
            sgn_s = (s == 0) ? 1 : -1;
            run_s = 1'b1;
            for (int i = 1; i < K; i++) begin
                r_s = int'(row) + sgn_s * dr_s * i;
                c_s = int'(col) + sgn_s * dc_s * i;
                if (run_s && (r_s >= 0) && (r_s < N) && (c_s >= 0) && (c_s < N)
                    && (board[r_s[CW-1:0]][c_s[CW-1:0]] == player)) begin
                    total_s = total_s + 1;
                end else begin
                    run_s = 1'b0;
                end
            end
        end
        count = QW'(total_s);
    end

endmodule

// File: rtl/ttt_board_nk.sv
// NxN board controller: validates moves, scans the four directions through the
// placed cell over four cycles, then reports win/draw or passes the turn.
module ttt_board_nk
    import ttt_pkg::*;
#(
    parameter int N = 3,
    parameter int K = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  move_valid,
    input  logic [1:0]            xoroin,
    input  logic [$clog2(N)-1:0]  rowin,
    input  logic [$clog2(N)-1:0]  colin,
    output logic                  ready,
    output logic                  err,
    output logic [1:0]            xoroout,
    output logic [$clog2(N)-1:0]  rowout,
    output logic [$clog2(N)-1:0]  colout,
    output logic [1:0]            win
);

    localparam int MW = $clog2(N*N+1);
    localparam int QW = $clog2(2*K);

    state_t          state_r;
    state_t          state_nx_s;
    logic [1:0]      board_r [N][N];
    cell_t           turn_r;
    logic [MW-1:0]   moves_r;
    dir_t            dir_r;
    logic            hit_r;

    logic [QW-1:0]   count_s;
    logic            in_range_s;
    logic            cell_empty_s;
    logic            accept_s;
    logic            reject_s;
    logic            hit_now_s;
    logic            full_s;

    ttt_line_count #(.N(N), .K(K)) u_line_count (
        .board  (board_r),
        .row    (rowout),
        .col    (colout),
        .dir    (dir_r),
        .player (cell_t'(xoroout)),
        .count  (count_s)
    );

    // target-cell lookup, only indexed when the coordinates are on the board
    always_comb begin
        in_range_s = (int'(rowin) < N) && (int'(colin) < N);
        if (in_range_s) begin
            cell_empty_s = (board_r[rowin][colin] == EMPTY);
        end else begin
            cell_empty_s = 1'b0;
        end
        hit_now_s = hit_r || (int'(count_s) >= K);
        full_s    = (int'(moves_r) == N*N);
    end

    // next-state and accept/reject decode
    always_comb begin
        state_nx_s = state_r;
        accept_s   = 1'b0;
        reject_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (move_valid) begin
                    if ((xoroin == turn_r) && in_range_s && cell_empty_s) begin
                        accept_s   = 1'b1;
                        state_nx_s = CHECK;
                    end else begin
                        reject_s = 1'b1;
                    end
                end else begin
                    state_nx_s = IDLE;
                end
            end
            CHECK: begin
                if (dir_r == DIR_ANTI) begin
                    state_nx_s = (hit_now_s || full_s) ? DONE : IDLE;
                end else begin
                    state_nx_s = CHECK;
                end
            end
            DONE: begin
                reject_s   = move_valid;
                state_nx_s = DONE;
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // state register and ready flag
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            ready   <= 1'b1;
        end else begin
            state_r <= state_nx_s;
            ready   <= (state_nx_s == IDLE);
        end
    end

    // board, turn, counter, scan progress and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    board_r[i][j] <= 2'b00;
                end
            end
            turn_r  <= X;
            moves_r <= '0;
            dir_r   <= DIR_ROW;
            hit_r   <= 1'b0;
            err     <= 1'b0;
            xoroout <= 2'b00;
            rowout  <= '0;
            colout  <= '0;
            win     <= 2'b00;
        end else begin
            err <= reject_s;
            if (accept_s) begin
                board_r[rowin][colin] <= xoroin;
                moves_r <= moves_r + MW'(1);
                xoroout <= xoroin;
                rowout  <= rowin;
                colout  <= colin;
                dir_r   <= DIR_ROW;
                hit_r   <= 1'b0;
            end else if (state_r == CHECK) begin
                hit_r <= hit_now_s;
                dir_r <= dir_t'(dir_r + 2'd1);
                // a win on the last free cell outranks the draw
                if (dir_r == DIR_ANTI) begin
                    if (hit_now_s) begin
                        win <= xoroout;
                    end else if (full_s) begin
                        win <= DRAW;
                    end else begin
                        turn_r <= other_player(turn_r);
                    end
                end else begin
                    win <= win;
                end
            end else begin
                hit_r <= hit_r;
            end
        end
    end

endmodule

// File: tb/tb_ttt_board_nk.sv
// Self-checking bench: a 3x3/K=3 and a 5x5/K=4 board driven from a move table,
// expected observations queued at drive time and compared when sampled.
module tb_ttt_board_nk;

    localparam logic [1:0] PX = 2'b01;
    localparam logic [1:0] PO = 2'b10;
    localparam logic [1:0] PB = 2'b11;
    localparam logic [1:0] W0 = 2'b00;
    localparam logic [1:0] WX = 2'b01;
    localparam logic [1:0] WD = 2'b11;

    typedef struct {
        logic       rst;
        logic       sel;
        logic [1:0] p;
        logic [2:0] r;
        logic [2:0] c;
        logic       acc;
        logic [1:0] win;
    } vec_t;

    typedef struct packed {
        logic       ready;
        logic       err;
        logic [1:0] xo;
        logic [2:0] r;
        logic [2:0] c;
        logic [1:0] win;
    } obs_t;

    logic       clk;
    logic       reset;
    logic       mv3;
    logic       mv5;
    logic [1:0] xo;
    logic [2:0] row;
    logic [2:0] col;

    logic       rdy3, err3, rdy5, err5;
    logic [1:0] xoo3, win3, xoo5, win5;
    logic [1:0] ro3, co3;
    logic [2:0] ro5, co5;

    int tests = 0;
    int fails = 0;

    logic [1:0] cur_win [2];
    logic [1:0] last_xo [2];
    logic [2:0] last_r  [2];
    logic [2:0] last_c  [2];

    obs_t sb [$];
    vec_t vecs [$];

    ttt_board_nk #(.N(3), .K(3)) dut3 (
        .clk(clk), .reset(reset), .move_valid(mv3), .xoroin(xo),
        .rowin(row[1:0]), .colin(col[1:0]), .ready(rdy3), .err(err3),
        .xoroout(xoo3), .rowout(ro3), .colout(co3), .win(win3)
    );

    ttt_board_nk #(.N(5), .K(4)) dut5 (
        .clk(clk), .reset(reset), .move_valid(mv5), .xoroin(xo),
        .rowin(row), .colin(col), .ready(rdy5), .err(err5),
        .xoroout(xoo5), .rowout(ro5), .colout(co5), .win(win5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic obs_t observe(logic s);
        obs_t o;
        if (s) o = '{rdy5, err5, xoo5, ro5, co5, win5};
        else   o = '{rdy3, err3, xoo3, {1'b0, ro3}, {1'b0, co3}, win3};
        return o;
    endfunction

    task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cmp_obs(string nm, obs_t a, obs_t e);
        chk({nm, ".ready"}, 8'(a.ready), 8'(e.ready));
        chk({nm, ".err"},   8'(a.err),   8'(e.err));
        chk({nm, ".xo"},    8'(a.xo),    8'(e.xo));
        chk({nm, ".row"},   8'(a.r),     8'(e.r));
        chk({nm, ".col"},   8'(a.c),     8'(e.c));
        chk({nm, ".win"},   8'(a.win),   8'(e.win));
    endtask

    task automatic clear_model();
        for (int s = 0; s < 2; s++) begin
            cur_win[s] = W0;
            last_xo[s] = 2'b00;
            last_r[s]  = 3'd0;
            last_c[s]  = 3'd0;
        end
    endtask

    // one-cycle reset with a legal move presented alongside it
    task automatic do_reset(string nm);
        obs_t e;
        @(negedge clk);
        reset = 1'b1; mv3 = 1'b1; mv5 = 1'b1; xo = PX; row = 3'd0; col = 3'd0;
        @(negedge clk);
        reset = 1'b0; mv3 = 1'b0; mv5 = 1'b0;
        clear_model();
        e = '{1'b1, 1'b0, 2'b00, 3'd0, 3'd0, 2'b00};
        cmp_obs({nm, ".d3"}, observe(1'b0), e);
        cmp_obs({nm, ".d5"}, observe(1'b1), e);
    endtask

    task automatic step(input vec_t v, input int id);
        obs_t  e;
        obs_t  a;
        string nm;
        int    s;
        s  = v.sel ? 1 : 0;
        nm = $sformatf("v%0d", id);
        @(negedge clk);
        xo = v.p; row = v.r; col = v.c;
        if (v.sel) mv5 = 1'b1; else mv3 = 1'b1;
        e.err   = !v.acc;
        e.ready = v.acc ? 1'b0 : (cur_win[s] == W0);
        e.xo    = v.acc ? v.p : last_xo[s];
        e.r     = v.acc ? v.r : last_r[s];
        e.c     = v.acc ? v.c : last_c[s];
        e.win   = cur_win[s];
        sb.push_back(e);
        @(posedge clk); #1;
        mv3 = 1'b0; mv5 = 1'b0;
        a = observe(v.sel);
        e = sb.pop_front();
        cmp_obs(nm, a, e);
        if (v.acc) begin
            last_xo[s] = v.p; last_r[s] = v.r; last_c[s] = v.c;
            for (int k = 0; k < 3; k++) begin
                @(posedge clk); #1;
                a = observe(v.sel);
                chk({nm, ".busy_ready"}, 8'(a.ready), 8'd0);
                chk({nm, ".busy_win"},   8'(a.win),   8'(cur_win[s]));
            end
            e.err   = 1'b0;
            e.ready = (v.win == W0);
            e.win   = v.win;
            sb.push_back(e);
            @(posedge clk); #1;
            cur_win[s] = v.win;
            a = observe(v.sel);
            e = sb.pop_front();
            cmp_obs({nm, ".res"}, a, e);
        end else begin
            @(posedge clk); #1;
            a = observe(v.sel);
            chk({nm, ".err_drop"}, 8'(a.err), 8'd0);
        end
    endtask

    function automatic vec_t mk(logic sel, logic [1:0] p, int r, int c, logic acc, logic [1:0] w);
        vec_t v;
        v.rst = 1'b0; v.sel = sel; v.p = p; v.r = 3'(r); v.c = 3'(c); v.acc = acc; v.win = w;
        return v;
    endfunction

    function automatic vec_t mk_rst();
        vec_t v;
        v = mk(1'b0, 2'b00, 0, 0, 1'b0, W0);
        v.rst = 1'b1;
        return v;
    endfunction

    initial begin
        reset = 1'b1; mv3 = 1'b0; mv5 = 1'b0; xo = 2'b00; row = 3'd0; col = 3'd0;
        clear_model();
        repeat (2) @(posedge clk);
        do_reset("reset_init");

        // row win for X on 3x3
        vecs.push_back(mk(0, PX, 0, 0, 1, W0));
        vecs.push_back(mk(0, PO, 1, 0, 1, W0));
        vecs.push_back(mk(0, PX, 0, 1, 1, W0));
        vecs.push_back(mk(0, PO, 1, 1, 1, W0));
        vecs.push_back(mk(0, PX, 0, 2, 1, WX));
        vecs.push_back(mk_rst());
        // rejections: wrong turn, occupied, out of range, illegal mover
        vecs.push_back(mk(0, PO, 0, 0, 0, W0));
        vecs.push_back(mk(0, PX, 0, 0, 1, W0));
        vecs.push_back(mk(0, PO, 0, 0, 0, W0));
        vecs.push_back(mk(0, PX, 1, 1, 0, W0));
        vecs.push_back(mk(0, PO, 3, 0, 0, W0));
        vecs.push_back(mk(0, PB, 1, 1, 0, W0));
        vecs.push_back(mk(0, PO, 0, 3, 0, W0));
        vecs.push_back(mk(0, PO, 1, 1, 1, W0));
        vecs.push_back(mk_rst());
        // full-board draw, then requests in DONE
        vecs.push_back(mk(0, PX, 0, 0, 1, W0));
        vecs.push_back(mk(0, PO, 0, 1, 1, W0));
        vecs.push_back(mk(0, PX, 0, 2, 1, W0));
        vecs.push_back(mk(0, PO, 1, 1, 1, W0));
        vecs.push_back(mk(0, PX, 1, 0, 1, W0));
        vecs.push_back(mk(0, PO, 1, 2, 1, W0));
        vecs.push_back(mk(0, PX, 2, 1, 1, W0));
        vecs.push_back(mk(0, PO, 2, 0, 1, W0));
        vecs.push_back(mk(0, PX, 2, 2, 1, WD));
        vecs.push_back(mk(0, PX, 0, 0, 0, WD));
        vecs.push_back(mk(0, PO, 2, 2, 0, WD));
        vecs.push_back(mk_rst());
        // X completes the anti-diagonal with the ninth move
        vecs.push_back(mk(0, PX, 0, 0, 1, W0));
        vecs.push_back(mk(0, PO, 0, 1, 1, W0));
        vecs.push_back(mk(0, PX, 0, 2, 1, W0));
        vecs.push_back(mk(0, PO, 1, 0, 1, W0));
        vecs.push_back(mk(0, PX, 2, 0, 1, W0));
        vecs.push_back(mk(0, PO, 1, 2, 1, W0));
        vecs.push_back(mk(0, PX, 2, 1, 1, W0));
        vecs.push_back(mk(0, PO, 2, 2, 1, W0));
        vecs.push_back(mk(0, PX, 1, 1, 1, WX));
        vecs.push_back(mk(0, PO, 0, 0, 0, WX));
        vecs.push_back(mk_rst());
        // 5x5, K=4: anti-diagonal X, three-long O run on row 4
        vecs.push_back(mk(1, PX, 0, 3, 1, W0));
        vecs.push_back(mk(1, PO, 4, 0, 1, W0));
        vecs.push_back(mk(1, PX, 1, 2, 1, W0));
        vecs.push_back(mk(1, PO, 4, 1, 1, W0));
        vecs.push_back(mk(1, PX, 2, 1, 1, W0));
        vecs.push_back(mk(1, PO, 4, 2, 1, W0));
        vecs.push_back(mk(1, PX, 3, 0, 1, WX));
        vecs.push_back(mk(1, PO, 4, 4, 0, WX));
        vecs.push_back(mk_rst());

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst) do_reset($sformatf("reset_v%0d", i));
            else             step(vecs[i], i);
        end

        // requests during CHECK are ignored; reset in CHECK aborts the pending win
        step(mk(0, PX, 0, 0, 1, W0), 100);
        step(mk(0, PO, 1, 0, 1, W0), 101);
        step(mk(0, PX, 0, 1, 1, W0), 102);
        step(mk(0, PO, 1, 1, 1, W0), 103);
        @(negedge clk);
        xo = PX; row = 3'd0; col = 3'd2; mv3 = 1'b1;
        @(posedge clk); #1;
        xo = PO; row = 3'd2; col = 3'd2;
        chk("mid_check.ready", 8'(rdy3), 8'd0);
        @(posedge clk); #1;
        mv3 = 1'b0;
        chk("ignore_in_check.err", 8'(err3), 8'd0);
        chk("ignore_in_check.ready", 8'(rdy3), 8'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        clear_model();
        cmp_obs("reset_in_check", observe(1'b0), '{1'b1, 1'b0, 2'b00, 3'd0, 3'd0, 2'b00});
        repeat (6) @(negedge clk);
        chk("aborted_check.win", 8'(win3), 8'd0);
        chk("aborted_check.ready", 8'(rdy3), 8'd1);
        step(mk(0, PX, 0, 0, 1, W0), 104);
        step(mk(0, PO, 2, 2, 1, W0), 105);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ttt_board_nk.md
TTT_BOARD_NK -- requirements
Module: ttt_board_nk

Interface
REQ-001 Parameter N, default 3, board edge length; legal range 3..8.
REQ-002 Parameter K, default 3, run length needed to win; legal range 3..N.
REQ-003 Localparam CW = $clog2(N), coordinate width; CW is at least 2.
REQ-004 clk  in  1  sole clock; all state SHALL update on the rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 move_valid  in  1  move request, qualified by ready.
REQ-007 xoroin  in  2  mover: 01=X, 10=O; 00 and 11 are illegal.
REQ-008 rowin, colin  in  CW each  target cell.
REQ-009 ready  out  1  high only in IDLE.
REQ-010 err  out  1  one-cycle pulse flagging a rejected request.
REQ-011 xoroout  out  2  player of the last accepted move.
REQ-012 rowout, colout  out  CW each  cell of the last accepted move.
REQ-013 win  out  2  00=none, 01=X won, 10=O won, 11=draw.

Function
REQ-014 Board SHALL be N*N 2-bit cells (00 empty); turn register starts at X; move counter width is $clog2(N*N+1).
REQ-015 FSM states: IDLE, CHECK, DONE.
REQ-016 A request is accepted when move_valid and ready are high and all of these hold: xoroin equals the current turn; rowin<N; colin<N; target cell empty.
REQ-017 Any other move_valid in IDLE SHALL be rejected: err=1 in the next cycle; board, turn, counter and outputs unchanged; FSM stays in IDLE.
REQ-018 Acceptance at edge t SHALL do all of the following:
  - write the cell;
  - increment the move counter;
  - load xoroout/rowout/colout (visible from cycle t+1);
  - enter CHECK with direction index d=0.
REQ-019 CHECK SHALL evaluate one direction per cycle, in order d=0 row, 1 column, 2 diagonal, 3 anti-diagonal (4 cycles).
REQ-020 Each evaluation SHALL count 1 + the contiguous same-player cells on both sides of the placed cell, up to K-1 per side, stopping at board edges.
REQ-021 A count >= K in any direction SHALL set a sticky hit flag; the remaining directions are still stepped.
REQ-022 At the edge ending d=3, the FSM SHALL resolve as follows:
  - hit: win=mover, DONE;
  - else counter==N*N: win=11, DONE;
  - else toggle turn, IDLE.
  Result visible from cycle t+5.
REQ-023 ready SHALL be low in CHECK and DONE; move_valid in CHECK SHALL be ignored with no err.
REQ-024 move_valid in DONE SHALL produce an err pulse; the board is frozen until reset.
REQ-025 A win on the final cell SHALL report the winner, not a draw.
REQ-026 err SHALL never be high for two consecutive cycles unless move_valid is held high across those cycles in IDLE or DONE.

Reset
REQ-027 reset SHALL take priority over every other input, including move_valid in the same cycle.
REQ-028 Reset values: all cells 00, turn X, counter 0, state IDLE, ready=1, err=0, xoroout=00, rowout=0, colout=0, win=00.
REQ-029 reset asserted during CHECK SHALL abort the check with no win/draw update; the next cycle shows reset values.

Structure
REQ-030 Package ttt_pkg SHALL hold:
  - the cell/player enum (EMPTY=00, X=01, O=10);
  - win codes (NONE, XWIN, OWIN, DRAW);
  - the FSM state enum;
  - the direction enum.
REQ-031 One sub-module, ttt_line_count, SHALL hold the combinational run counter. Inputs: board, position, direction, player. Output: count. It carries the same N/K parameters.
REQ-032 The top level SHALL hold the board storage, FSM, turn and move counter registers.

Verification
REQ-033 N=3,K=3: X(0,0) O(1,0) X(0,1) O(1,1) X(0,2) -> each accept leaves ready low 4 cycles; win=01 at cycle t+5 after the last move; rowout=0, colout=2.
REQ-034 N=3,K=3: O moves first at (0,0) -> err=1 one cycle, ready stays 1, win=00; then X(0,0) is accepted; X(0,0) again as O -> err, cell unchanged.
REQ-035 N=3: rowin=3 or xoroin=11 -> err pulse; the 9-move draw sequence X00 O01 X02 O11 X10 O12 X21 O20 X22 -> win=11.
REQ-036 N=5,K=4: X anti-diagonal (0,3)(1,2)(2,1)(3,0) interleaved with O moves on row 4 -> win=01 only after the 4th X; 3-long runs give no win.
REQ-037 Reset asserted 2 cycles after an accept (in CHECK), and again in DONE -> next cycle ready=1, win=00, all cells empty; X(0,0) is then accepted.
REQ-038 Win on the 9th move (N=3) -> win=01, not 11; move_valid in DONE -> err pulse, outputs unchanged.
